// File: rtl/spi_16b_arbiter_pkg.sv
// Shared types and defaults for the spi_16b requester arbiter.
// Word width, default sizing and the arbiter state set.
package spi_pkg;

  localparam int SPI_WORD_W  = 16;
  localparam int N_REQ_DEF   = 4;
  localparam int GAP_CYC_DEF = 2;

  typedef logic [SPI_WORD_W-1:0] spi_word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    WAIT_LOW = 2'd2,
    GAP      = 2'd3
  } spi_arb_state_t;

endpackage

// File: rtl/spi_16b_arbiter_if.sv
// Requester handshake plus the spi_16b drive/done bundle.
// slave = arbiter side, master = requesters and serialiser side.
interface spi_16b_arbiter_if
  import spi_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();

  logic [N_REQ-1:0]      req_valid;
  spi_word_t [N_REQ-1:0] req_data;
  logic [N_REQ-1:0]      req_lock;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      req_done;
  logic                  spi_en;
  spi_word_t             spi_data_out;
  logic                  spi_done;

  modport slave (
    input  req_valid, req_data, req_lock, spi_done,
    output req_ready, req_done, spi_en, spi_data_out
  );

  modport master (
    output req_valid, req_data, req_lock, spi_done,
    input  req_ready, req_done, spi_en, spi_data_out
  );

endinterface

// File: rtl/spi_16b_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Produces a one-hot grant and its index; zero grant when req is empty.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   j;
  logic hit;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!hit && req[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_16b_arbiter.sv
// Round-robin arbiter sharing one spi_16b serialiser between requesters,
// with per-owner burst lock and a minimum idle gap between words.
module spi_16b_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spi_16b_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_XFER = XFER;
  localparam logic [1:0] S_WAIT = WAIT_LOW;
  localparam logic [1:0] S_GAP  = GAP;

  logic [1:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic             lock_active;
  logic [GW-1:0]    gap_cnt;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win;
  logic             hold_owner;

  assign owner_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << owner_id;
  assign hold_owner = lock_active & bus.req_lock[owner_id];

  // A held lock narrows the candidates to the current owner only.
  assign cand = hold_owner ? (bus.req_valid & owner_oh)
                           : bus.req_valid;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win)
  );

  assign bus.req_ready = (rst_n && state == S_IDLE) ? grant : '0;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      lock_active      <= 1'b0;
      gap_cnt          <= '0;
      owner_id         <= '0;
      bus.spi_en       <= 1'b0;
      bus.spi_data_out <= '0;
      bus.req_done     <= '0;
    end else begin
      bus.req_done <= '0;
      unique case (state)
        S_IDLE: begin
          if (lock_active && !bus.req_lock[owner_id])
            lock_active <= 1'b0;
          if (|grant) begin
            bus.spi_data_out <= bus.req_data[win];
            bus.spi_en       <= 1'b1;
            owner_id         <= win;
            rr_ptr           <= (win == IW'(N_REQ - 1))
                                ? '0 : win + IW'(1);
            state            <= S_XFER;
          end
        end
        S_XFER: begin
          if (bus.spi_done) begin
            bus.spi_en   <= 1'b0;
            bus.req_done <= owner_oh;
            lock_active  <= bus.req_lock[owner_id];
            state        <= S_WAIT;
          end
        end
        // A done held high must not complete the next word.
        S_WAIT: begin
          if (!bus.spi_done) begin
            if (GAP_CYC == 0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= GW'(GAP_CYC);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt <= GW'(1))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_16b_arbiter.sv
// Randomised and directed bench for spi_16b_arbiter against a
// timestamp-based reference model and a behavioural spi_16b.
`timescale 1ns/1ps
module tb_spi_16b_arbiter;
  import spi_pkg::*;

  localparam int N = 4;
  localparam int G = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] owner_id;
  logic       busy;

  spi_16b_arbiter_if #(.N_REQ(N)) bus ();

  spi_16b_arbiter #(.N_REQ(N), .GAP_CYC(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .owner_id (owner_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester agents: each word is {lock_after_word, data}.
  logic [16:0]  q [N][$];
  logic [N-1:0] pend;
  logic [N-1:0] nxt_lock;
  logic [16:0]  head;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        bus.req_valid[i] <= 1'b0;
        bus.req_lock[i]  <= 1'b0;
        pend[i]          <= 1'b0;
        nxt_lock[i]      <= 1'b0;
        q[i].delete();
      end else if (bus.req_valid[i] && bus.req_ready[i]) begin
        bus.req_valid[i] <= 1'b0;
        bus.req_lock[i]  <= nxt_lock[i];
        pend[i]          <= 1'b1;
      end else if (pend[i]) begin
        if (bus.req_done[i]) pend[i] <= 1'b0;
      end else if (!bus.req_valid[i] && q[i].size() > 0) begin
        head = q[i].pop_front();
        bus.req_data[i]  <= head[15:0];
        nxt_lock[i]      <= head[16];
        bus.req_valid[i] <= 1'b1;
      end
    end
  end

  // Behavioural spi_16b: done after xfer_len enabled cycles, held
  // for hold_cfg extra cycles once spi_en has fallen.
  int xfer_len = 40;
  int hold_cfg = 0;
  int en_cnt;
  int hold_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      en_cnt       <= 0;
      hold_left    <= 0;
      bus.spi_done <= 1'b0;
    end else if (bus.spi_en) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt + 1 >= xfer_len) begin
        bus.spi_done <= 1'b1;
        hold_left    <= hold_cfg;
      end
    end else begin
      en_cnt <= 0;
      if (bus.spi_done) begin
        if (hold_left > 0) hold_left <= hold_left - 1;
        else bus.spi_done <= 1'b0;
      end
    end
  end

  // Reference model: ownership, rotation and timing as timestamps.
  int          cyc         = 0;
  int          m_rr        = 0;
  int          m_owner     = 0;
  int          m_idle_from = 0;
  int          m_done_cyc  = -1;
  bit          m_lock      = 1'b0;
  bit          m_inflight  = 1'b0;
  bit          m_done_seen = 1'b0;
  logic [15:0] m_data      = 16'h0000;

  function automatic int pick_winner();
    logic [N-1:0] elig;
    elig = bus.req_valid;
    if (m_lock && bus.req_lock[m_owner]) begin
      elig          = '0;
      elig[m_owner] = bus.req_valid[m_owner];
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (elig[j] === 1'b1) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    exp_ready = '0;
    if (!m_inflight && cyc >= m_idle_from) begin
      w = pick_winner();
      if (w >= 0) exp_ready[w] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_rr        <= 0;
      m_owner     <= 0;
      m_idle_from <= 0;
      m_done_cyc  <= -1;
      m_lock      <= 1'b0;
      m_inflight  <= 1'b0;
      m_done_seen <= 1'b0;
      m_data      <= 16'h0000;
    end else if (m_inflight) begin
      if (!m_done_seen && bus.spi_done) begin
        m_done_seen <= 1'b1;
        m_done_cyc  <= cyc + 1;
        m_lock      <= bus.req_lock[m_owner];
      end else if (m_done_seen && !bus.spi_done) begin
        m_inflight  <= 1'b0;
        m_idle_from <= cyc + 1 + G;
      end
    end else if (cyc >= m_idle_from) begin
      if (m_lock && !bus.req_lock[m_owner]) m_lock <= 1'b0;
      if (pick_winner() >= 0) begin
        m_owner     <= pick_winner();
        m_rr        <= (pick_winner() + 1) % N;
        m_data      <= bus.req_data[pick_winner()];
        m_inflight  <= 1'b1;
        m_done_seen <= 1'b0;
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  logic [15:0] wire_log [$];
  int          done_pulses = 0;
  int          fall_cyc    = -1;
  logic        prev_en     = 1'b0;
  logic        prev_done   = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_en   <= 1'b0;
      prev_done <= 1'b0;
      fall_cyc  <= -1;
    end else begin
      chk("ready", bus.req_ready, exp_ready());
      chk("spi_en", bus.spi_en, m_inflight && !m_done_seen);
      chk("req_done", bus.req_done,
          (cyc == m_done_cyc) ? (1 << m_owner) : 0);
      chk("busy", busy, m_inflight || cyc < m_idle_from);
      chk("owner", owner_id, m_owner);
      chk("data", bus.spi_data_out, m_data);
      if (bus.spi_en && !prev_en) begin
        wire_log.push_back(bus.spi_data_out);
        if (fall_cyc >= 0) chk("gap", (cyc - fall_cyc) >= G + 1, 1);
      end
      if (!bus.spi_done && prev_done) fall_cyc <= cyc;
      done_pulses <= done_pulses + $countones(bus.req_done);
      prev_en     <= bus.spi_en;
      prev_done   <= bus.spi_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input int budget);
    int t = 0;
    while (wire_log.size() < n && t < budget) begin
      step();
      t++;
    end
    chk("wait_log", wire_log.size() >= n, 1);
  endtask

  function automatic bit all_quiet();
    all_quiet = !busy && !bus.spi_en && (bus.req_valid == '0)
                && (pend == '0);
    for (int i = 0; i < N; i++)
      if (q[i].size() != 0) all_quiet = 1'b0;
  endfunction

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!all_quiet() && t < budget) begin
      step();
      t++;
    end
    chk("wait_idle", all_quiet(), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_en", bus.spi_en, 0);
    chk("rst_data", bus.spi_data_out, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int base;
  int p0;
  int pushed;
  int r;
  int blen;

  initial begin
    do_reset();

    // Single word from requester 0.
    base = wire_log.size();
    q[0].push_back({1'b0, 16'hAA00});
    wait_log(base + 1, 200);
    chk("single", wire_log[base], 16'hAA00);
    wait_idle(300);

    // Round-robin from a fresh pointer.
    do_reset();
    base = wire_log.size();
    q[0].push_back({1'b0, 16'h1111});
    q[1].push_back({1'b0, 16'h2222});
    q[2].push_back({1'b0, 16'h3333});
    q[3].push_back({1'b0, 16'h4444});
    wait_log(base + 4, 600);
    chk("rr0", wire_log[base],     16'h1111);
    chk("rr1", wire_log[base + 1], 16'h2222);
    chk("rr2", wire_log[base + 2], 16'h3333);
    chk("rr3", wire_log[base + 3], 16'h4444);
    wait_idle(300);

    base = wire_log.size();
    q[2].push_back({1'b0, 16'h2B2B});
    wait_log(base + 1, 200);
    q[1].push_back({1'b0, 16'h1B1B});
    q[3].push_back({1'b0, 16'h3B3B});
    wait_log(base + 3, 600);
    chk("rr_after2_a", wire_log[base + 1], 16'h3B3B);
    chk("rr_after2_b", wire_log[base + 2], 16'h1B1B);
    wait_idle(300);

    // Locked burst from requester 1 holds off requester 2.
    base = wire_log.size();
    q[1].push_back({1'b1, 16'h2A00});
    q[1].push_back({1'b1, 16'h2A01});
    q[1].push_back({1'b0, 16'h2A02});
    wait_log(base + 1, 200);
    q[2].push_back({1'b0, 16'h5555});
    wait_log(base + 4, 1000);
    chk("lock0", wire_log[base],     16'h2A00);
    chk("lock1", wire_log[base + 1], 16'h2A01);
    chk("lock2", wire_log[base + 2], 16'h2A02);
    chk("lock3", wire_log[base + 3], 16'h5555);
    wait_idle(300);

    // Done held high after spi_en falls.
    hold_cfg = 20;
    base     = wire_log.size();
    p0       = done_pulses;
    q[0].push_back({1'b0, 16'hC0C0});
    q[3].push_back({1'b0, 16'hC3C3});
    wait_log(base + 2, 800);
    wait_idle(400);
    chk("held_order", wire_log[base], 16'hC3C3);
    chk("held_pulses", done_pulses - p0, 2);
    hold_cfg = 0;

    // Reset during a requester-2 transfer.
    base = wire_log.size();
    q[2].push_back({1'b0, 16'hD2D2});
    wait_log(base + 1, 200);
    repeat (10) step();
    p0 = done_pulses;
    do_reset();
    base = wire_log.size();
    q[0].push_back({1'b0, 16'hE0E0});
    q[2].push_back({1'b0, 16'hE2E2});
    wait_log(base + 2, 600);
    wait_idle(300);
    chk("post_rst0", wire_log[base],     16'hE0E0);
    chk("post_rst1", wire_log[base + 1], 16'hE2E2);
    chk("abort_done", done_pulses - p0, 2);

    // Random bursts, lengths and done-hold times.
    base   = wire_log.size();
    pushed = 0;
    for (int it = 0; it < 60; it++) begin
      xfer_len = $urandom_range(8, 2);
      hold_cfg = $urandom_range(3, 0);
      r        = $urandom_range(N - 1, 0);
      if (q[r].size() == 0 && !pend[r] && !bus.req_valid[r]) begin
        blen = $urandom_range(3, 1);
        for (int k = 0; k < blen; k++) begin
          q[r].push_back({(k < blen - 1) ? 1'b1 : 1'b0,
                          16'($urandom)});
          pushed++;
        end
      end
      repeat ($urandom_range(30, 0)) step();
    end
    wait_idle(5000);
    chk("rand_count", wire_log.size() - base, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_16b_arbiter.md
# spi_16b_arbiter

Shares one `spi_16b` serialiser between up to `N_REQ` requesters, such as the LCD init sequencer, the frame/tile pusher and the debug port. It accepts 16-bit words over a valid/ready handshake and grants them round-robin. Each granted word is driven to `spi_16b` via `spi_en`/`spi_data_out`, and completion is returned to the owning requester. A per-requester lock keeps multi-word command/data bursts contiguous, and a programmable gap enforces minimum idle time between words.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, range 2..8.
- `GAP_CYC`, 2: minimum idle cycles between `spi_en` falling and the next acceptance. 0 means no gap.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a word.
- `req_data`  in  N_REQ x 16  word per requester. Must be stable while `req_valid[i]` is high.
- `req_lock`  in  N_REQ  requester i keeps ownership after its current word.
- `req_ready`  out  N_REQ  word accepted this cycle (combinational, one-hot or zero).
- `req_done`  out  N_REQ  one-cycle pulse: requester i's word finished on the wire.
- `owner_id`  out  $clog2(N_REQ)  index of the current/last grantee.
- `busy`  out  1  state != IDLE.
- `spi_en`  out  1  to `spi_16b`. Held high for the whole transfer.
- `spi_data_out`  out  16  to `spi_16b`. Stable while `spi_en` is high.
- `spi_done`  in  1  from `spi_16b`. Treated as a level; may be a pulse or held.

## Operation

States: IDLE, XFER, WAIT_LOW, GAP.

- **IDLE**
  - If `lock_active`: only `owner_id` may be granted. Other requesters stall.
  - Otherwise the winner is the first `req_valid` bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready[win]` is high combinationally.
  - On that edge: `spi_data_out <= req_data[win]`, `spi_en <= 1`, `owner_id <= win`, `rr_ptr <= (win+1) mod N_REQ`. Go to XFER.
- **XFER**: hold `spi_en`. On the first edge where `spi_done==1`:
  - `spi_en <= 0`.
  - `req_done[owner_id]` pulses for 1 cycle.
  - `lock_active <= req_lock[owner_id]`.
  - Go to WAIT_LOW.
- **WAIT_LOW**: wait for `spi_done==0`. This prevents a held-high done from completing the next word.
  - On exit, load `gap_cnt <= GAP_CYC`, then go to GAP. If `GAP_CYC==0`, go straight to IDLE.
- **GAP**: decrement `gap_cnt` each cycle. At 0 go to IDLE.
- **Lock release**: in IDLE, if `lock_active` and `req_lock[owner_id]==0`, clear `lock_active` that cycle. Normal round-robin applies in the same cycle.
- **No valid request**: stay in IDLE. `req_ready` is all 0.
- **Simultaneous requests**: exactly one grant per acceptance; there is never more than one `req_ready` bit high.

## Timing

- **Reset values**: `spi_en=0`, `spi_data_out=16'h0000`, `req_ready=0`, `req_done=0`, `owner_id=0`, `busy=0`, `rr_ptr=0`, `lock_active=0`, state IDLE.
- **Reset mid-transfer**: `spi_en` drops asynchronously. No `req_done` is issued for the aborted word.
- **Acceptance to `spi_en`**: the handshake edge sets `spi_en`, so it is high in the next cycle.
- **`spi_done` to completion**: `spi_done` sampled high at edge t means `spi_en` is low and `req_done` is high in cycle t+1.
- **Word-to-word minimum**: `spi_done` low observed, then GAP_CYC cycles, then IDLE. The next acceptance can be no earlier than that IDLE cycle.
- **Back-to-back throughput**: one word per (transfer + 2 + GAP_CYC) cycles.
- **Input validity**: `req_data`/`req_lock` are sampled only on the cycles defined above. A requester may drop `req_valid` without handshake only while `req_ready` is low.

## Structure

- **Package `spi_pkg`**: `spi_arb_state_t` enum {IDLE, XFER, WAIT_LOW, GAP}, `SPI_WORD_W=16`, default `N_REQ`, default `GAP_CYC`.
- **Sub-module `rr_pick`**: combinational round-robin picker.
  - Inputs: `req` mask and `ptr`. Outputs: one-hot `grant` and `idx`.
  - Instantiated once. The lock override is applied by masking `req` in the parent.
- **Top `spi_16b_arbiter`** holds the FSM, gap counter, lock flag, and the output registers that drive `spi_16b` directly.

## Test plan

Use a `spi_16b` behavioural model with done = 1 after 40 cycles, held until `spi_en` falls.

- **Single word**: `req_valid[0]`, data `16'hAA00`.
  - `req_ready[0]` in the same cycle, `spi_en` next cycle with `spi_data_out=AA00`.
  - `req_done[0]` one cycle after `spi_done`; `spi_en` low that cycle.
- **Round-robin**: all four valid with `1111`/`2222`/`3333`/`4444`.
  - Wire order must be 1111, 2222, 3333, 4444.
  - Then assert req1 and req3 after a grant to req2: req3 is served before req1.
- **Lock burst**: req1 sends `2A00`, `2A01`, `2A02` with `req_lock[1]=1` (dropped on the last word); req2 is valid throughout.
  - All three req1 words are sent before req2's `5555`.
- **Gap**: `GAP_CYC=4`. Between `spi_done` falling and the next `spi_en` rise there must be at least 5 cycles; `busy` stays high during GAP.
- **Held done**: the model holds `spi_done` high for 20 cycles after `spi_en` falls.
  - No new `spi_en` until `spi_done` returns low.
  - Exactly one `req_done` pulse.
- **Reset mid-XFER**: pull `rst_n` low 10 cycles into a req2 transfer.
  - `spi_en=0` immediately; all outputs at reset values; no `req_done[2]`.
  - After release, with req0 and req2 valid, req0 is granted first.
